// File: rtl/vga_timing_out.sv
// Raster scan generator and VGA output stage: counts pixels/lines, hands the
// position to the drawing objects and realigns their colour with sync/blank.
module vga_timing_out #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned MUX_LAT  = 1,
  parameter bit          SYNC_ACT = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pixEn,
  input  logic [7:0]  redIn,
  input  logic [7:0]  greenIn,
  input  logic [7:0]  blueIn,
  output logic [10:0] pixelX,
  output logic [10:0] pixelY,
  output logic        drawEn,
  output logic        startOfFrame,
  output logic [7:0]  vgaR,
  output logic [7:0]  vgaG,
  output logic [7:0]  vgaB,
  output logic        hsync,
  output logic        vsync,
  output logic        blankN
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  localparam logic        SYNC_IDLE = ~SYNC_ACT;

  typedef struct packed {
    logic hs;
    logic vs;
    logic blank;
  } ctl_t;

  localparam ctl_t CTL_IDLE = '{hs: SYNC_IDLE, vs: SYNC_IDLE, blank: 1'b1};

  logic [10:0] h_cnt;
  logic [10:0] v_cnt;
  logic [10:0] h_nxt;
  logic [10:0] v_nxt;
  logic        h_wrap;
  logic        v_wrap;

  always_comb begin
    h_wrap = (h_cnt == 11'(H_TOTAL - 1));
    v_wrap = (v_cnt == 11'(V_TOTAL - 1));
    h_nxt  = h_cnt;
    v_nxt  = v_cnt;
    if (pixEn) begin
      if (h_wrap) begin
        h_nxt = '0;
        v_nxt = v_wrap ? '0 : v_cnt + 11'd1;
      end else begin
        h_nxt = h_cnt + 11'd1;
      end
    end
  end

  // drawEn is computed from the next position so it lines up with pixelX/pixelY
  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt        <= '0;
      v_cnt        <= '0;
      drawEn       <= 1'b0;
      startOfFrame <= 1'b0;
    end else begin
      h_cnt        <= h_nxt;
      v_cnt        <= v_nxt;
      drawEn       <= (h_nxt < 11'(H_ACTIVE)) && (v_nxt < 11'(V_ACTIVE));
      startOfFrame <= pixEn && h_wrap && v_wrap;
    end
  end

  assign pixelX = h_cnt;
  assign pixelY = v_cnt;

  ctl_t raw_ctl;
  ctl_t dly_ctl;

  always_comb begin
    raw_ctl.hs    = ((h_cnt >= 11'(HS_START)) && (h_cnt < 11'(HS_END))) ? SYNC_ACT : SYNC_IDLE;
    raw_ctl.vs    = ((v_cnt >= 11'(VS_START)) && (v_cnt < 11'(VS_END))) ? SYNC_ACT : SYNC_IDLE;
    raw_ctl.blank = ~drawEn;
  end

  // Matches the objects mux latency; runs every clk, independent of pixEn.
  generate
    if (MUX_LAT == 0) begin : g_no_pipe
      assign dly_ctl = raw_ctl;
    end else begin : g_pipe
      ctl_t pipe [MUX_LAT];

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < int'(MUX_LAT); i++) pipe[i] <= CTL_IDLE;
        end else begin
          pipe[0] <= raw_ctl;
          for (int i = 1; i < int'(MUX_LAT); i++) pipe[i] <= pipe[i-1];
        end
      end

      assign dly_ctl = pipe[MUX_LAT-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      vgaR   <= '0;
      vgaG   <= '0;
      vgaB   <= '0;
      hsync  <= SYNC_IDLE;
      vsync  <= SYNC_IDLE;
      blankN <= 1'b0;
    end else begin
      vgaR   <= dly_ctl.blank ? 8'h00 : redIn;
      vgaG   <= dly_ctl.blank ? 8'h00 : greenIn;
      vgaB   <= dly_ctl.blank ? 8'h00 : blueIn;
      hsync  <= dly_ctl.hs;
      vsync  <= dly_ctl.vs;
      blankN <= ~dly_ctl.blank;
    end
  end

endmodule

// File: tb/tb_vga_timing_out.sv
// Scoreboard bench for vga_timing_out on a reduced 30x15 raster so full
// frames fit in a short run; the objects mux is modelled as a 1-clk register.
module tb_vga_timing_out;

  localparam int HA = 16, HFP = 4, HS = 6, HBP = 4, HT = 30;
  localparam int VA = 8,  VFP = 2, VS = 2, VBP = 3, VT = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pixEn = 1'b1;
  logic [7:0]  redIn, greenIn, blueIn;
  logic [10:0] pixelX, pixelY;
  logic        drawEn, startOfFrame;
  logic [7:0]  vgaR, vgaG, vgaB;
  logic        hsync, vsync, blankN;

  always #5 clk = ~clk;

  vga_timing_out #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .MUX_LAT(1), .SYNC_ACT(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .pixEn(pixEn),
    .redIn(redIn), .greenIn(greenIn), .blueIn(blueIn),
    .pixelX(pixelX), .pixelY(pixelY), .drawEn(drawEn), .startOfFrame(startOfFrame),
    .vgaR(vgaR), .vgaG(vgaG), .vgaB(vgaB),
    .hsync(hsync), .vsync(vsync), .blankN(blankN)
  );

  // objects mux stand-in
  logic ff_mode = 1'b0;
  always @(posedge clk) begin
    if (ff_mode) {redIn, greenIn, blueIn} <= 24'hFFFFFF;
    else         {redIn, greenIn, blueIn} <= {pixelX[7:0], pixelY[7:0], 8'hA5};
  end

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic        draw;
    logic        sof;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic        hs;
    logic        vs;
    logic        bn;
  } rec_t;

  rec_t q[$];
  int   compared = 0;
  int   mismatched = 0;

  // reference model state
  int          m_h = 0, m_v = 0;
  bit          m_draw = 0;
  bit          st_hs = 1, st_vs = 1, st_blank = 1;
  logic [23:0] m_mux = '0;
  bit          cfg_ff = 0;

  int sof_total = 0;
  int hs_run = 0, vs_run = 0, last_hs = 0, last_vs = 0;

  task automatic step(input bit rst, input bit en);
    rec_t e;
    bit   hs_raw, vs_raw;
    @(negedge clk);
    reset   = rst;
    pixEn   = en;
    ff_mode = cfg_ff;
    hs_raw = !((m_h >= HA + HFP) && (m_h < HA + HFP + HS));
    vs_raw = !((m_v >= VA + VFP) && (m_v < VA + VFP + VS));
    e.hs = rst ? 1'b1 : st_hs;
    e.vs = rst ? 1'b1 : st_vs;
    e.bn = rst ? 1'b0 : !st_blank;
    {e.r, e.g, e.b} = (rst || st_blank) ? 24'h0 : m_mux;
    if (rst) {st_hs, st_vs, st_blank} = 3'b111;
    else     {st_hs, st_vs, st_blank} = {hs_raw, vs_raw, !m_draw};
    m_mux = cfg_ff ? 24'hFFFFFF : {8'(m_h), 8'(m_v), 8'hA5};
    e.sof = !rst && en && (m_h == HT - 1) && (m_v == VT - 1);
    if (rst) begin
      m_h = 0;
      m_v = 0;
    end else if (en) begin
      if (m_h == HT - 1) begin
        m_h = 0;
        m_v = (m_v == VT - 1) ? 0 : m_v + 1;
      end else begin
        m_h = m_h + 1;
      end
    end
    m_draw = !rst && (m_h < HA) && (m_v < VA);
    e.x = 11'(m_h);
    e.y = 11'(m_v);
    e.draw = m_draw;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input int got, input int exp);
    compared++;
    if (got != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // monitor: pops one expectation per clk edge and tracks pulse widths
  initial begin
    rec_t e, g;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        g = '{x: pixelX, y: pixelY, draw: drawEn, sof: startOfFrame,
              r: vgaR, g: vgaG, b: vgaB, hs: hsync, vs: vsync, bn: blankN};
        compared++;
        if (g !== e) begin
          mismatched++;
          $display("FAIL cycle_rec t=%0t got x=%0d y=%0d de=%b sof=%b rgb=%h%h%h hs=%b vs=%b bn=%b exp x=%0d y=%0d de=%b sof=%b rgb=%h%h%h hs=%b vs=%b bn=%b",
                   $time, g.x, g.y, g.draw, g.sof, g.r, g.g, g.b, g.hs, g.vs, g.bn,
                   e.x, e.y, e.draw, e.sof, e.r, e.g, e.b, e.hs, e.vs, e.bn);
        end
      end
      if (startOfFrame === 1'b1) sof_total++;
      if (hsync === 1'b0) hs_run++;
      else if (hs_run > 0) begin last_hs = hs_run; hs_run = 0; end
      if (vsync === 1'b0) vs_run++;
      else if (vs_run > 0) begin last_vs = vs_run; vs_run = 0; end
    end
  end

  initial begin
    int s0;
    repeat (3) step(1, 1);
    settle();
    chk("reset_pixelX", pixelX, 0);
    chk("reset_drawEn", drawEn, 0);
    chk("reset_hsync", hsync, 1);
    chk("reset_blankN", blankN, 0);

    // one full line: back to x=0 on line 1, no frame pulse yet
    repeat (HT) step(0, 1);
    settle();
    chk("line_wrap_x", pixelX, 0);
    chk("line_wrap_y", pixelY, 1);
    chk("no_sof_first_line", sof_total, 0);

    s0 = sof_total;
    repeat (460) step(0, 1);
    settle();
    chk("sof_per_frame", sof_total - s0, 1);
    chk("vsync_width", last_vs, 60);
    chk("hsync_width", last_hs, 6);

    cfg_ff = 1;
    repeat (HT * VT) step(0, 1);
    cfg_ff = 0;

    repeat (2 * HT * 2) begin
      step(0, 1);
      step(0, 0);
    end
    settle();
    chk("hsync_width_half_rate", last_hs, 12);

    // reset while both syncs are asserted at the output
    for (int i = 0; i < 1000 && !(m_h == 22 && m_v == 10); i++) step(0, 1);
    settle();
    chk("pre_reset_x", pixelX, 22);
    chk("pre_reset_y", pixelY, 10);
    chk("pre_reset_hsync", hsync, 0);
    chk("pre_reset_vsync", vsync, 0);
    step(1, 1);
    settle();
    chk("midreset_x", pixelX, 0);
    chk("midreset_y", pixelY, 0);
    chk("midreset_hsync", hsync, 1);
    chk("midreset_vsync", vsync, 1);
    chk("midreset_blankN", blankN, 0);
    chk("midreset_vgaR", vgaR, 0);

    repeat (HT * 2) step(0, 1);
    settle();
    chk("resume_x", pixelX, 0);
    chk("resume_y", pixelY, 2);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    chk("queue_drain", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
